shifter_arbiter: RTL and testbench
==================================

Name: shifter_arbiter

Overview:
- Shares one SHIFTER barrel-shifter instance between two requesters. Example requesters: the ALU shift path and a future multiply/divide helper.
- Arbitrates round-robin, captures the winning operands into a register stage, and presents the shift result with a valid/ready handshake.
- Throughput is one operation per clock. Latency is one cycle from acceptance to response.
- Sits between the execute-stage requesters and the existing SHIFTER.

Parameters:
- DATA_W, 32, operand/result width; fixed to match SHIFTER.
- SA_W, 5, shift-amount width; fixed to match SHIFTER.
- CNT_W, 16, width of per-requester grant counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_data  input  DATA_W  requester 0 operand.
- req0_sa  input  SA_W  requester 0 shift amount.
- req0_right  input  1  1 = shift right, 0 = shift left.
- req0_arith  input  1  1 = arithmetic (right shifts only).
- req1_valid, req1_ready, req1_data, req1_sa, req1_right, req1_arith: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  DATA_W  shift result.
- rsp_id  output  1  requester that issued the result.
- cnt0  output  CNT_W  grants issued to requester 0.
- cnt1  output  CNT_W  grants issued to requester 1.

Behaviour:
- Reset (async on rst_n low) sets:
  - rsp_valid=0, rsp_id=0, cnt0=0, cnt1=0.
  - Operand registers = 0.
  - last_grant=1, so requester 0 wins the first tie.
  - State = IDLE.
- States:
  - IDLE: no result held.
  - HOLD: result held, rsp_valid=1.
- can_accept = (state==IDLE) | rsp_ready. This is combinational, so back-to-back operations proceed when rsp_ready stays high.
- Grant:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - reqN_ready = can_accept & grant==N & reqN_valid. At most one ready per cycle; ready never asserts without the matching valid.
- On acceptance (rising edge):
  - Capture data, sa, right, arith and id into the operand registers.
  - last_grant <= id; cntN increments.
  - State <= HOLD.
- HOLD:
  - rsp_data = SHIFTER output driven from the operand registers. rsp_id = captured id.
  - rsp_data and rsp_id stay stable while rsp_valid & !rsp_ready.
- Exit from HOLD:
  - rsp_ready=1 with no new acceptance: state <= IDLE.
  - rsp_ready=1 with a new acceptance in the same cycle: stay in HOLD with new operands.
- Shift semantics (SHIFTER):
  - Right=0: logical left; Arith ignored.
  - Right=1, Arith=0: logical right.
  - Right=1, Arith=1: sign-fill right.
  - Sa=0 passes data unchanged.
- Counters wrap modulo 2^CNT_W with no saturation.
- Requests with valid low are ignored regardless of operand values. Operands may change freely while not ready.
- rst_n asserted mid-operation: the held result is discarded and rsp_valid drops immediately (async). No response is produced after reset release until a new acceptance.
- No combinational path from reqN_valid to rsp_valid; rsp_valid is registered state.

Decomposition:
- Shared package holds:
  - DATA_W and SA_W constants.
  - State encoding (IDLE=0, HOLD=1).
  - Requester id constants REQ_ALU=0, REQ_AUX=1.
- One sub-module: shifter_rr_arb2, the 2-way round-robin grant logic with the last_grant register.
- SHIFTER is instantiated unchanged.

Test Plan:
- Single req0: data=FFFFFFFF, sa=2, right=1, arith=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=FFFFFFFF, rsp_id=0, cnt0=1.
- Logical variants on req1:
  - data=FFFFFFFF, sa=2, right=1, arith=0 -> 3FFFFFFF, rsp_id=1.
  - right=0, arith=1 -> FFFFFFFC.
- Both valid every cycle for 4 cycles, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; cnt0=2, cnt1=2.
- Backpressure: accept req0 (data=80000000, sa=31, right=1, arith=1), then hold rsp_ready=0 for 3 cycles with req1 valid -> req1_ready=0 throughout; rsp_data stays FFFFFFFF. Raise rsp_ready -> req1 accepted the same cycle.
- Reset mid-HOLD: drop rst_n while rsp_valid=1 -> rsp_valid=0 and counters=0 immediately. After release, the first tie goes to requester 0.
- Counter wrap with CNT_W=4: 17 grants to req0 -> cnt0=1.

Source files
------------

// File: rtl/shifter_arbiter_pkg.sv
// Shared constants, state encoding and operand record for the shift arbiter.
package shifter_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SA_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SA_W-1:0]   sa;
        logic              right;
        logic              arith;
        logic              id;
    } op_t;

endpackage

// File: rtl/shifter_arbiter_if.sv
// Requester, response and counter signals between the execute stage and the arbiter.
interface shifter_arbiter_if
    import shifter_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [SA_W-1:0]   req0_sa;
    logic              req0_right;
    logic              req0_arith;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [SA_W-1:0]   req1_sa;
    logic              req1_right;
    logic              req1_arith;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;

    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    modport master (
        output req0_valid, req0_data, req0_sa, req0_right, req0_arith,
        output req1_valid, req1_data, req1_sa, req1_right, req1_arith,
        output rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_data, req0_sa, req0_right, req0_arith,
        input  req1_valid, req1_data, req1_sa, req1_right, req1_arith,
        input  rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, cnt0, cnt1
    );

endinterface

// File: rtl/shifter.sv
// Barrel shifter: logical left, logical right or sign-filling right.
module shifter
    import shifter_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [SA_W-1:0]   sa,
    input  logic              right,
    input  logic              arith,
    output logic [DATA_W-1:0] result_c
);

    // Arith only matters for right shifts.
    always_comb begin
        result_c = data << sa;
        if (right) begin
            if (arith) begin
                result_c = DATA_W'($signed(data) >>> sa);
            end else begin
                result_c = data >> sa;
            end
        end
    end

endmodule

// File: rtl/shifter_rr_arb2.sv
// Two-way round-robin grant with the last-grant history register.
module shifter_rr_arb2
    import shifter_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant_c
);

    logic last_grant_q;
    logic last_grant_d;

    // A lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_c      = REQ_ALU;
        last_grant_d = last_grant_q;
        if (valid0 && valid1) begin
            grant_c = ~last_grant_q;
        end else if (valid1) begin
            grant_c = REQ_AUX;
        end
        if (advance) begin
            last_grant_d = grant_c;
        end
    end

    // Reset to requester 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_AUX;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Shares one shifter between two requesters with a one-deep registered response.
module shifter_arbiter
    import shifter_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    shifter_arbiter_if.slave    bus
);

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic can_accept_c;
    logic grant_c;
    logic accept_c;

    shifter_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .advance (accept_c),
        .grant_c (grant_c)
    );

    // Slot is free when empty or when the held result leaves this cycle.
    assign can_accept_c   = (state_q == IDLE) || bus.rsp_ready;
    assign accept_c       = can_accept_c && (grant_c ? bus.req1_valid : bus.req0_valid);
    assign bus.req0_ready = can_accept_c && (grant_c == REQ_ALU) && bus.req0_valid;
    assign bus.req1_ready = can_accept_c && (grant_c == REQ_AUX) && bus.req1_valid;

    // Next state, operand capture and grant counting.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (accept_c) begin
            state_d = HOLD;
            if (grant_c == REQ_AUX) begin
                op_d   = '{data: bus.req1_data, sa: bus.req1_sa, right: bus.req1_right,
                           arith: bus.req1_arith, id: REQ_AUX};
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                op_d   = '{data: bus.req0_data, sa: bus.req0_sa, right: bus.req0_right,
                           arith: bus.req0_arith, id: REQ_ALU};
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end else if (state_q == HOLD && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State, operand and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    shifter u_shifter (
        .data     (op_q.data),
        .sa       (op_q.sa),
        .right    (op_q.right),
        .arith    (op_q.arith),
        .result_c (bus.rsp_data)
    );

    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_id    = op_q.id;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: vector table plus multi-cycle sequences.
module tb_shifter_arbiter;

    localparam int unsigned CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    shifter_arbiter_if #(.CNT_W(CNT_W)) bus ();

    shifter_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic [4:0]  sa0;
        logic        r0;
        logic        a0;
        logic        v1;
        logic [31:0] d1;
        logic [4:0]  sa1;
        logic        r1;
        logic        a1;
        logic        rr;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_id;
        logic [3:0]  e_c0;
        logic [3:0]  e_c1;
    } vec_t;

    vec_t vec[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] sa0,
                         input logic r0, input logic a0,
                         input logic v1, input logic [31:0] d1, input logic [4:0] sa1,
                         input logic r1, input logic a1, input logic rr);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_sa    = sa0;
        bus.req0_right = r0;
        bus.req0_arith = a0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_sa    = sa1;
        bus.req1_right = r1;
        bus.req1_arith = a1;
        bus.rsp_ready  = rr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        vec[0] = '{1'b1, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 4'd1, 4'd0};
        vec[1] = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, 1'b1,
                   1'b0, 1'b1, 1'b1, 32'h3FFF_FFFF, 1'b1, 4'd1, 4'd1};
        vec[2] = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 4'd1, 4'd2};
        vec[3] = '{1'b1, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 4'd2, 4'd2};
        vec[4] = '{1'b0, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 5'd3, 1'b1, 1'b0, 1'b1,
                   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd2, 4'd2};
        vec[5] = '{1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 4'd3, 4'd2};
        vec[6] = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 5'd4, 1'b1, 1'b1, 1'b1,
                   1'b0, 1'b1, 1'b1, 32'h07FF_FFFF, 1'b1, 4'd3, 4'd3};
        vec[7] = '{1'b1, 32'h0F0F_0F0F, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, 1'b1, 32'h00F0_F0F0, 1'b0, 4'd4, 4'd3};

        #23;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("reset_cnt0", 32'(bus.cnt0), 32'h0);
        chk("reset_cnt1", 32'(bus.cnt1), 32'h0);
        rst_n = 1'b1;
        step();

        // Vector table: ready checked before the edge, response after it.
        for (int i = 0; i < 8; i++) begin
            drive(vec[i].v0, vec[i].d0, vec[i].sa0, vec[i].r0, vec[i].a0,
                  vec[i].v1, vec[i].d1, vec[i].sa1, vec[i].r1, vec[i].a1, vec[i].rr);
            #1;
            chk($sformatf("vec%0d_req0_ready", i), 32'(bus.req0_ready), 32'(vec[i].e_rdy0));
            chk($sformatf("vec%0d_req1_ready", i), 32'(bus.req1_ready), 32'(vec[i].e_rdy1));
            step();
            chk($sformatf("vec%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vec[i].e_vld));
            if (vec[i].e_vld) begin
                chk($sformatf("vec%0d_rsp_data", i), bus.rsp_data, vec[i].e_data);
                chk($sformatf("vec%0d_rsp_id", i), 32'(bus.rsp_id), 32'(vec[i].e_id));
            end
            chk($sformatf("vec%0d_cnt0", i), 32'(bus.cnt0), 32'(vec[i].e_c0));
            chk($sformatf("vec%0d_cnt1", i), 32'(bus.cnt1), 32'(vec[i].e_c1));
        end

        // Reset while a result is held: outputs clear without a clock edge.
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("async_reset_cnt0", 32'(bus.cnt0), 32'h0);
        chk("async_reset_cnt1", 32'(bus.cnt1), 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("post_reset_no_rsp", 32'(bus.rsp_valid), 32'h0);

        // Both requesters valid every cycle: grants alternate starting at 0.
        drive(1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 5'd4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_req0_ready", i), 32'(bus.req0_ready), 32'((i % 2) == 0));
            chk($sformatf("rr%0d_req1_ready", i), 32'(bus.req1_ready), 32'((i % 2) == 1));
            step();
            chk($sformatf("rr%0d_rsp_id", i), 32'(bus.rsp_id), 32'(i % 2));
            chk($sformatf("rr%0d_rsp_data", i), bus.rsp_data,
                ((i % 2) == 0) ? 32'h0000_0002 : 32'h0000_0010);
        end
        chk("rr_cnt0", 32'(bus.cnt0), 32'd2);
        chk("rr_cnt1", 32'(bus.cnt1), 32'd2);

        // Backpressure: held result stays put and req1 waits.
        drive(1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("bp_first_data", bus.rsp_data, 32'hFFFF_FFFF);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_00F0, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_req1_ready", i), 32'(bus.req1_ready), 32'h0);
            step();
            chk($sformatf("bp%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'h1);
            chk($sformatf("bp%0d_rsp_data", i), bus.rsp_data, 32'hFFFF_FFFF);
            chk($sformatf("bp%0d_rsp_id", i), 32'(bus.rsp_id), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_req1_ready", 32'(bus.req1_ready), 32'h1);
        step();
        chk("bp_release_rsp_data", bus.rsp_data, 32'h0000_000F);
        chk("bp_release_rsp_id", 32'(bus.rsp_id), 32'h1);
        chk("bp_cnt0", 32'(bus.cnt0), 32'd3);
        chk("bp_cnt1", 32'(bus.cnt1), 32'd3);

        // Counter wrap: 17 grants to req0 on a 4-bit counter.
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        drive(1'b1, 32'h0000_0003, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step();
        end
        chk("wrap_cnt0", 32'(bus.cnt0), 32'd1);
        chk("wrap_cnt1", 32'(bus.cnt1), 32'd0);
        chk("wrap_rsp_data", bus.rsp_data, 32'h0000_0006);
        bus.req0_valid = 1'b0;
        step();
        chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
